// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - video RAM arbiter: CPU store drain plus frame scan-out prefetch
// One RAM operation per cycle; urgent scan-out beats CPU drain, which beats background prefetch.
module vram_arbiter #(
  parameter int ADDR_W      = 12,
  parameter int FRAME_WORDS = 2400,
  parameter int WFIFO_DEPTH = 4,
  parameter int PFIFO_DEPTH = 8,
  parameter int LOW_WATER   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              write_enable,
  input  logic [1:0]        window_size,
  input  logic [ADDR_W+1:0] data_addr,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic              frame_start,
  input  logic              pix_pop,
  output logic              pix_valid,
  output logic [31:0]       pix_data,
  output logic              wr_overflow,
  output logic              wr_misalign,
  output logic              pix_underflow
);

  localparam int WA_W = $clog2(WFIFO_DEPTH);
  localparam int WC_W = $clog2(WFIFO_DEPTH + 1);
  localparam int PA_W = $clog2(PFIFO_DEPTH);
  localparam int PC_W = $clog2(PFIFO_DEPTH + 1);
  localparam int OC_W = PC_W + 1;
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FRAME_WORDS - 1);
  localparam logic [WC_W-1:0]   W_FULL    = WC_W'(WFIFO_DEPTH);
  localparam logic [OC_W-1:0]   P_DEPTH   = OC_W'(PFIFO_DEPTH);
  localparam logic [OC_W-1:0]   P_LOW     = OC_W'(LOW_WATER);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] scan_addr;
  // rd_v1: read is on the RAM bus; rd_v2: its data is on ram_rdata and is pushed this cycle
  logic              rd_v1;
  logic              rd_v2;

  logic [ADDR_W-1:0] wf_addr [WFIFO_DEPTH];
  logic [3:0]        wf_be   [WFIFO_DEPTH];
  logic [31:0]       wf_data [WFIFO_DEPTH];
  logic [WA_W-1:0]   wf_wr;
  logic [WA_W-1:0]   wf_rd;
  logic [WC_W-1:0]   wf_count;

  logic [31:0]       pf_mem [PFIFO_DEPTH];
  logic [PA_W-1:0]   pf_wr;
  logic [PA_W-1:0]   pf_rd;
  logic [PC_W-1:0]   pf_count;

  logic [1:0]        lane;
  logic              st_req;
  logic              st_mis;
  logic              st_push;
  logic              wf_full;
  logic [3:0]        st_be;
  logic [31:0]       st_data;
  logic [OC_W-1:0]   occ;
  logic              fetching;
  logic              space;
  logic              urgent;
  logic              gnt_rd;
  logic              gnt_wr;
  logic              pop_ok;

  always_comb begin
    lane    = data_addr[1:0];
    st_req  = sel && write_enable && (window_size != 2'b11);
    st_be   = 4'b0000;
    st_data = 32'h0;
    st_mis  = 1'b0;
    case (window_size)
      2'b00: begin
        st_be   = 4'b0001 << lane;
        st_data = {24'h0, data_in[7:0]} << {lane, 3'b000};
      end
      2'b01: begin
        st_mis  = lane[0];
        st_be   = 4'b0011 << lane;
        st_data = {16'h0, data_in[15:0]} << {lane, 3'b000};
      end
      2'b10: begin
        st_mis  = (lane != 2'b00);
        st_be   = 4'b1111;
        st_data = data_in;
      end
      default: ;
    endcase
    // Full is judged on the count at the start of the cycle, ignoring a same-cycle drain
    wf_full  = (wf_count == W_FULL);
    st_push  = st_req && !st_mis && !wf_full;
    occ      = OC_W'(pf_count) + OC_W'(rd_v1) + OC_W'(rd_v2);
    fetching = (state == S_FETCH) && !frame_start;
    space    = (occ < P_DEPTH);
    urgent   = fetching && space && (occ <= P_LOW);
    gnt_wr   = !urgent && (wf_count != '0);
    gnt_rd   = urgent || (fetching && space && (wf_count == '0));
    pop_ok   = pix_pop && !frame_start && (pf_count != '0);
  end

  assign data_out  = 32'h0;
  assign pix_valid = (pf_count != '0);
  assign pix_data  = pix_valid ? pf_mem[pf_rd] : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      scan_addr     <= '0;
      rd_v1         <= 1'b0;
      rd_v2         <= 1'b0;
      ram_addr      <= '0;
      ram_we        <= 1'b0;
      ram_be        <= 4'b0000;
      ram_wdata     <= 32'h0;
      wf_wr         <= '0;
      wf_rd         <= '0;
      wf_count      <= '0;
      pf_wr         <= '0;
      pf_rd         <= '0;
      pf_count      <= '0;
      wr_overflow   <= 1'b0;
      wr_misalign   <= 1'b0;
      pix_underflow <= 1'b0;
    end else begin
      ram_we    <= gnt_wr;
      ram_be    <= gnt_wr ? wf_be[wf_rd] : 4'b0000;
      ram_wdata <= gnt_wr ? wf_data[wf_rd] : 32'h0;
      ram_addr  <= gnt_wr ? wf_addr[wf_rd] : (gnt_rd ? scan_addr : '0);

      if (st_push) begin
        wf_addr[wf_wr] <= data_addr[ADDR_W+1:2];
        wf_be[wf_wr]   <= st_be;
        wf_data[wf_wr] <= st_data;
        wf_wr          <= wf_wr + 1'b1;
      end
      if (gnt_wr) wf_rd <= wf_rd + 1'b1;
      wf_count <= wf_count + WC_W'(st_push) - WC_W'(gnt_wr);
      if (st_req && st_mis) wr_misalign <= 1'b1;
      if (st_req && !st_mis && wf_full) wr_overflow <= 1'b1;

      if (frame_start) begin
        // Restart the scan; anything already requested belongs to the old frame
        state     <= S_FETCH;
        scan_addr <= '0;
        rd_v1     <= 1'b0;
        rd_v2     <= 1'b0;
        pf_wr     <= '0;
        pf_rd     <= '0;
        pf_count  <= '0;
      end else begin
        rd_v1 <= gnt_rd;
        rd_v2 <= rd_v1;
        if (gnt_rd) begin
          scan_addr <= scan_addr + 1'b1;
          if (scan_addr == LAST_WORD) state <= S_DONE;
        end
        if (rd_v2) begin
          pf_mem[pf_wr] <= ram_rdata;
          pf_wr         <= pf_wr + 1'b1;
        end
        if (pop_ok) pf_rd <= pf_rd + 1'b1;
        if (pix_pop && (pf_count == '0)) pix_underflow <= 1'b1;
        pf_count <= pf_count + PC_W'(rd_v2) - PC_W'(pop_ok);
      end
    end
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Video-RAM arbiter and scan-out sequencer for the VGA device (device #4). Shares one single-port, synchronous-read 32-bit video RAM between two requesters: buffered CPU stores arriving through the memory controller, and a sequential frame prefetcher that fills a pixel FIFO for the VGA timing generator. One RAM operation is issued per cycle. Priority: urgent scan-out first, then CPU write drain, then background prefetch.

## Interface
- ADDR_W, 12, video RAM word-address width
- FRAME_WORDS, 2400, words fetched per frame; 320x240 at 1 bpp
- WFIFO_DEPTH, 4, CPU write FIFO entries; power of two
- PFIFO_DEPTH, 8, pixel FIFO entries; power of two
- LOW_WATER, 2, urgency threshold for scan-out
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sel  in  1  data_device == 4
- write_enable  in  1  CPU store strobe
- window_size  in  2  access size: 00 byte, 01 half, 10 word, 11 no access
- data_addr  in  ADDR_W+2  local byte address
- data_in  in  32  store data, right-aligned
- data_out  out  32  CPU read data; always 0 because VRAM is write-only from the CPU
- ram_addr  out  ADDR_W  RAM word address
- ram_we  out  1  RAM write strobe
- ram_be  out  4  RAM byte enables
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid the cycle after the read is issued
- frame_start  in  1  one-cycle pulse marking the start of a frame
- pix_pop  in  1  consume the pixel FIFO head
- pix_valid  out  1  pixel FIFO is non-empty
- pix_data  out  32  pixel FIFO head; first-word-fall-through
- wr_overflow  out  1  sticky: a store was dropped
- wr_misalign  out  1  sticky: a misaligned store was dropped
- pix_underflow  out  1  sticky: pix_pop was asserted while empty

## Operation
- Store accept condition: sel && write_enable && window_size != 11.
- Lane mapping, using lane = data_addr[1:0]:
  - byte: be = 1<<lane; data_in[7:0] placed on that lane.
  - half: requires lane[0]=0; be = 0011<<lane; data_in[15:0] placed on the lane.
  - word: requires lane=00; be = 1111.
- A misaligned store is dropped and sets wr_misalign.
- Each write FIFO entry holds {word address, be, data}.
- Full check uses the registered count at the start of the cycle. A store arriving while the FIFO is full is dropped and sets wr_overflow, even if a drain happens in the same cycle.
- Scan FSM states:
  - IDLE: after reset, no fetches.
  - FETCH: on frame_start, scan_addr=0.
  - DONE: entered after word FRAME_WORDS-1 has been issued. No fetches until the next frame_start.
- "Space" means pcount + inflight < PFIFO_DEPTH. "Urgent" means FETCH && pcount + inflight <= LOW_WATER && space.
- Per-cycle grant:
  - if urgent: scan read at scan_addr;
  - else if the write FIFO is non-empty: write the head entry (ram_we=1, ram_be, ram_wdata);
  - else if FETCH && space: scan read;
  - else no operation (ram_we=0, ram_be=0).
- A scan read increments scan_addr. The read data is pushed into the pixel FIFO the following cycle.
- frame_start, in any state and including mid-frame:
  - flush the pixel FIFO;
  - mark any in-flight read result as discarded;
  - set scan_addr=0 and enter FETCH.
  - A pix_pop in the same cycle is ignored.
  - The write FIFO is untouched.
- pix_pop while empty has no effect except setting pix_underflow.
- Sticky flags clear only on rst.

## Timing
- Reset state:
  - all outputs 0;
  - both FIFOs empty, inflight=0, FSM IDLE.
- ram_* outputs are registered. An operation granted in cycle N appears on ram_* in cycle N+1, and read data returns at N+2.
- Inflight accounting covers reads issued but not yet pushed, so the pixel FIFO never overflows.
- Store-to-RAM latency: 2 cycles when the write FIFO is empty and no urgent scan is pending.
- pix_valid rises in the cycle after the data is pushed.
- Pop and push in the same cycle leave the count unchanged.
- Write FIFO enqueue and dequeue in the same cycle on a non-full FIFO are both performed.
- Steady state: one RAM operation per cycle, so write drain bandwidth equals the slots not used by scan reads.

## Test plan
- Reset, then no stimulus for 20 cycles -> ram_we=0, pix_valid=0, all flags 0, no RAM reads issued.
- Word store of 0xDEADBEEF to byte address 0x010, then byte store of 0xA5 to 0x013 -> RAM writes word 4 with be=1111 data 0xDEADBEEF, then word 4 with be=1000 data 0xA5000000.
- Half store to address 0x001 -> no RAM write; wr_misalign=1.
- Five word stores on consecutive cycles while the pixel FIFO is urgent so no drain occurs (WFIFO_DEPTH=4) -> first four drained in order later; fifth dropped; wr_overflow=1.
- frame_start with RAM preloaded word[i]=i, popping every 4th cycle -> pix_data sequence 0,1,2,... through 2399; no fetch after word 2399; pix_underflow stays 0.
- frame_start reasserted at word 100 with a read in flight -> next pix_data is 0; the stale word is never presented.
